// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D cache memory-port arbiter.
package cache_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE    = 2'd0;
    localparam arb_state_t SERVE_I = 2'd1;
    localparam arb_state_t SERVE_D = 2'd2;
    localparam arb_state_t RECOVER = 2'd3;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick between the I-cache and D-cache requesters.
module arb_rr2
    import cache_arb_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  requester_t last_grant,
    output requester_t grant
);

    always_comb begin
        grant = REQ_I;
        if (req_i && req_d) begin
            // On a tie the side that was not served last time wins.
            grant = (last_grant == REQ_D) ? REQ_I : REQ_D;
        end else if (req_d) begin
            grant = REQ_D;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache, one whole
// transaction at a time, with round-robin on conflict.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] icache_pmem_address,
    input  logic              icache_pmem_read,
    output logic [LINE_W-1:0] icache_pmem_rdata,
    output logic              icache_pmem_resp,
    input  logic [ADDR_W-1:0] dcache_pmem_address,
    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [LINE_W-1:0] dcache_pmem_wdata,
    output logic [LINE_W-1:0] dcache_pmem_rdata,
    output logic              dcache_pmem_resp,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t state_q, state_d;
    requester_t last_grant_q;
    requester_t grant;
    logic       op_write_q;
    logic       req_i, req_d;
    logic       take;
    logic       serving;

    assign req_i = icache_pmem_read;
    assign req_d = dcache_pmem_read | dcache_pmem_write;
    assign take  = (state_q == IDLE) && (req_i || req_d);

    arb_rr2 u_rr2 (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = (grant == REQ_I) ? SERVE_I : SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = RECOVER;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_D;
            op_write_q   <= 1'b0;
            mem_address  <= '0;
            mem_wdata    <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                last_grant_q <= grant;
                if (grant == REQ_I) begin
                    mem_address <= icache_pmem_address;
                    op_write_q  <= 1'b0;
                end else begin
                    mem_address <= dcache_pmem_address;
                    mem_wdata   <= dcache_pmem_wdata;
                    // Read and write together is illegal; write takes precedence.
                    op_write_q  <= dcache_pmem_write;
                end
            end
        end
    end

    assign serving   = (state_q == SERVE_I) || (state_q == SERVE_D);
    assign mem_read  = serving && !op_write_q;
    assign mem_write = serving && op_write_q;

    assign icache_pmem_resp  = (state_q == SERVE_I) && mem_resp;
    assign dcache_pmem_resp  = (state_q == SERVE_D) && mem_resp;
    assign icache_pmem_rdata = mem_rdata;
    assign dcache_pmem_rdata = mem_rdata;

    assert property (@(posedge clk) disable iff (rst)
        !(dcache_pmem_read && dcache_pmem_write));

    assert property (@(posedge clk) disable iff (rst)
        mem_resp |-> serving);

endmodule
